can_tx_prio_queue: RTL

Parametrised successor to the CAN transmit priority buffer. It holds up to N pending frames sorted by identifier, lowest ID first, and offers the head frame to the CAN transmitter through an explicit offer/ack/done/lost handshake. A frame that loses arbitration is re-queued in priority order. The block sits between the host register interface and the CAN TX bit engine.

---
 rtl/can_tx_prio_if.sv | 41 ++++
 rtl/can_tx_prio_queue.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/can_tx_prio_if.sv
// Bus bundle between the CAN TX priority queue and its environment:
// host write channel plus the offer/ack/done/lost transmitter handshake.
interface can_tx_prio_if #(
    parameter int unsigned ID_W  = 11,
    parameter int unsigned CNT_W = 4
);
    // host write channel
    logic             wr_valid;
    logic             wr_ready;
    logic [ID_W-1:0]  req_id;
    logic [3:0]       req_dlc;
    logic [7:0]       req_data [0:7];

    // transmitter handshake
    logic             start_tx;
    logic [ID_W-1:0]  tx_id;
    logic [3:0]       tx_dlc;
    logic [7:0]       tx_data [0:7];
    logic             tx_ack;
    logic             tx_done;
    logic             tx_lost;

    // status
    logic             done;
    logic             drop;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;

    // environment side: host and CAN bit engine
    modport master (
        output wr_valid, req_id, req_dlc, req_data, tx_ack, tx_done, tx_lost,
        input  wr_ready, start_tx, tx_id, tx_dlc, tx_data, done, drop, count, full, empty
    );

    // queue side
    modport slave (
        input  wr_valid, req_id, req_dlc, req_data, tx_ack, tx_done, tx_lost,
        output wr_ready, start_tx, tx_id, tx_dlc, tx_data, done, drop, count, full, empty
    );
endinterface

// File: rtl/can_tx_prio_queue.sv
// CAN transmit priority queue: up to N frames kept sorted by ascending ID
// (FIFO among equal IDs), head offered to the TX engine, frames losing
// arbitration re-queued ahead of equal IDs.
// Optional feature macro: CAN_TX_RETRY_LIMIT_EN -- drop a frame after
// MAX_RETRY arbitration losses (retry counter per entry).
module can_tx_prio_queue #(
    parameter int unsigned N         = 8,
    parameter int unsigned ID_W      = 11,
    parameter int          MAX_RETRY = 3,
    parameter int unsigned CNT_W     = $clog2(N + 1)
) (
    input  logic            clk,
    input  logic            rst,
    can_tx_prio_if.slave    bus
);

    localparam int unsigned DW = 64;
`ifdef CAN_TX_RETRY_LIMIT_EN
    localparam int unsigned RTY_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
`endif

    // elaboration-time parameter sanity
    if (N < 2) begin : g_chk_n
        $error("can_tx_prio_queue: N must be at least 2");
    end
    if (MAX_RETRY < 0) begin : g_chk_retry
        $error("can_tx_prio_queue: MAX_RETRY must be non-negative");
    end

    typedef enum logic [1:0] {IDLE, OFFER, BUSY} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [ID_W-1:0]   q_id   [N];
    logic [3:0]        q_dlc  [N];
    logic [DW-1:0]     q_data [N];
    logic [ID_W-1:0]   qd_id   [N];
    logic [3:0]        qd_dlc  [N];
    logic [DW-1:0]     qd_data [N];
    logic [ID_W-1:0]   s_id   [N];
    logic [3:0]        s_dlc  [N];
    logic [DW-1:0]     s_data [N];

    logic [ID_W-1:0]   cur_id;
    logic [3:0]        cur_dlc;
    logic [DW-1:0]     cur_data;

`ifdef CAN_TX_RETRY_LIMIT_EN
    logic [RTY_W-1:0]  q_retry  [N];
    logic [RTY_W-1:0]  qd_retry [N];
    logic [RTY_W-1:0]  s_retry  [N];
    logic [RTY_W-1:0]  cur_retry;
    logic              drop_q;
`endif

    logic              done_q;
    logic [DW-1:0]     wr_data;
    logic [DW-1:0]     tx_word;

    logic              in_busy, wr_ready_c, acc_wr;
    logic              ack_ev, done_ev, lost_ev, drop_ev, reins_ev, ins_valid;
    logic [CNT_W-1:0]  qlen, len_s, qn_next, pos;

    // request payload packed as byte lanes, byte 0 in the low bits
    always_comb begin
        wr_data = '0;
        for (int j = 0; j < 8; j++) begin
            wr_data[8*j +: 8] = bus.req_data[j];
        end
    end

    // handshake events qualified by state; tx_done wins over tx_lost
    assign in_busy    = (state_q == BUSY);
    assign wr_ready_c = (cnt_q < CNT_W'(N)) && !(in_busy && bus.tx_lost);
    assign acc_wr     = bus.wr_valid && wr_ready_c;
    assign ack_ev     = (state_q == OFFER) && bus.tx_ack;
    assign done_ev    = in_busy && bus.tx_done;
    assign lost_ev    = in_busy && bus.tx_lost && !bus.tx_done;
`ifdef CAN_TX_RETRY_LIMIT_EN
    assign drop_ev    = lost_ev && (cur_retry == RTY_W'(MAX_RETRY));
`else
    assign drop_ev    = 1'b0;
`endif
    assign reins_ev   = lost_ev && !drop_ev;
    assign ins_valid  = acc_wr || reins_ev;

    // queued entries exclude the in-flight frame held in cur
    assign qlen    = cnt_q - CNT_W'(in_busy);
    assign len_s   = qlen - CNT_W'(ack_ev);
    assign qn_next = len_s + CNT_W'(ins_valid);
    assign cnt_d   = cnt_q + CNT_W'(acc_wr) - CNT_W'(done_ev) - CNT_W'(drop_ev);

    // next queue contents: optional head pop, then one sorted insertion
    always_comb begin
        s_id   = q_id;
        s_dlc  = q_dlc;
        s_data = q_data;
`ifdef CAN_TX_RETRY_LIMIT_EN
        s_retry = q_retry;
`endif
        if (ack_ev) begin
            for (int i = 0; i < N - 1; i++) begin
                s_id[i]   = q_id[i+1];
                s_dlc[i]  = q_dlc[i+1];
                s_data[i] = q_data[i+1];
`ifdef CAN_TX_RETRY_LIMIT_EN
                s_retry[i] = q_retry[i+1];
`endif
            end
        end

        // re-queued frames go ahead of equal IDs, new writes behind them
        pos = '0;
        for (int i = 0; i < N; i++) begin
            if (CNT_W'(i) < len_s) begin
                if (reins_ev ? (s_id[i] < cur_id) : (s_id[i] <= bus.req_id)) begin
                    pos = pos + CNT_W'(1);
                end
            end
        end

        for (int i = 0; i < N; i++) begin
            if (!ins_valid || (CNT_W'(i) < pos)) begin
                qd_id[i]   = s_id[i];
                qd_dlc[i]  = s_dlc[i];
                qd_data[i] = s_data[i];
`ifdef CAN_TX_RETRY_LIMIT_EN
                qd_retry[i] = s_retry[i];
`endif
            end else if (CNT_W'(i) == pos) begin
                qd_id[i]   = reins_ev ? cur_id   : bus.req_id;
                qd_dlc[i]  = reins_ev ? cur_dlc  : bus.req_dlc;
                qd_data[i] = reins_ev ? cur_data : wr_data;
`ifdef CAN_TX_RETRY_LIMIT_EN
                qd_retry[i] = reins_ev ? (cur_retry + RTY_W'(1)) : '0;
`endif
            end else begin
                qd_id[i]   = s_id[(i > 0) ? i - 1 : 0];
                qd_dlc[i]  = s_dlc[(i > 0) ? i - 1 : 0];
                qd_data[i] = s_data[(i > 0) ? i - 1 : 0];
`ifdef CAN_TX_RETRY_LIMIT_EN
                qd_retry[i] = s_retry[(i > 0) ? i - 1 : 0];
`endif
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and offered-frame outputs
    always_comb begin
        state_d      = state_q;
        bus.start_tx = 1'b0;
        bus.tx_id    = '0;
        bus.tx_dlc   = '0;
        tx_word      = '0;
        case (state_q)
            IDLE: begin
                if (qn_next != '0) state_d = OFFER;
            end
            OFFER: begin
                bus.start_tx = 1'b1;
                bus.tx_id    = q_id[0];
                bus.tx_dlc   = q_dlc[0];
                tx_word      = q_data[0];
                if (ack_ev) state_d = BUSY;
            end
            BUSY: begin
                bus.tx_id  = cur_id;
                bus.tx_dlc = cur_dlc;
                tx_word    = cur_data;
                if (done_ev || lost_ev) state_d = (qn_next != '0) ? OFFER : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // offered frame payload back to byte lanes
    always_comb begin
        for (int j = 0; j < 8; j++) begin
            bus.tx_data[j] = tx_word[8*j +: 8];
        end
    end

    // queue storage, in-flight frame, occupancy and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            cur_id   <= '0;
            cur_dlc  <= '0;
            cur_data <= '0;
            done_q   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                q_id[i]   <= '0;
                q_dlc[i]  <= '0;
                q_data[i] <= '0;
`ifdef CAN_TX_RETRY_LIMIT_EN
                q_retry[i] <= '0;
`endif
            end
`ifdef CAN_TX_RETRY_LIMIT_EN
            cur_retry <= '0;
            drop_q    <= 1'b0;
`endif
        end else begin
            cnt_q  <= cnt_d;
            q_id   <= qd_id;
            q_dlc  <= qd_dlc;
            q_data <= qd_data;
            done_q <= done_ev;
            if (ack_ev) begin
                cur_id   <= q_id[0];
                cur_dlc  <= q_dlc[0];
                cur_data <= q_data[0];
`ifdef CAN_TX_RETRY_LIMIT_EN
                cur_retry <= q_retry[0];
`endif
            end
`ifdef CAN_TX_RETRY_LIMIT_EN
            q_retry <= qd_retry;
            drop_q  <= drop_ev;
`endif
        end
    end

    // status outputs
    assign bus.wr_ready = wr_ready_c;
    assign bus.count    = cnt_q;
    assign bus.full     = (cnt_q == CNT_W'(N));
    assign bus.empty    = (cnt_q == '0);
    assign bus.done     = done_q;
`ifdef CAN_TX_RETRY_LIMIT_EN
    assign bus.drop     = drop_q;
`else
    assign bus.drop     = 1'b0;
`endif

endmodule
